// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: sequences multi-cycle MUL/DIV in EX,
// merges stall requests into one per-stage hold vector, forwards flushes.
module pipe_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id_i,
  input  logic             stallreq_mem_i,
  input  logic             mc_start_i,
  input  logic             mc_op_i,
  input  logic             flush_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic             mc_busy_o,
  output logic             mc_done_o,
  output logic             mc_op_o,
  output logic [CNT_W-1:0] mc_cnt_o,
  output logic [31:0]      stall_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] MUL_LEN = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LEN = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [5:0] HOLD_MEM = 6'b011111;
  localparam logic [5:0] HOLD_EX  = 6'b001111;
  localparam logic [5:0] HOLD_ID  = 6'b000111;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_op;
  logic             w_op_nxt;
  logic [31:0]      r_stall_cnt;
  logic             w_ex_req;
  logic [5:0]       w_stall;

  // A MEM stall freezes the whole pipe, so the sequencer neither starts,
  // counts down nor retires while it is asserted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mc_start_i && !stallreq_mem_i) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = mc_op_i ? DIV_LEN : MUL_LEN;
            w_op_nxt    = mc_op_i;
          end
        end
        S_RUN: begin
          if (!stallreq_mem_i) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          // mc_start_i is still high from the retiring op here; ignore it.
          if (!stallreq_mem_i) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_ex_req = ((r_state == S_IDLE) && mc_start_i) || (r_state == S_RUN);

  always_comb begin
    w_stall = '0;
    if (rst || flush_i) begin
      w_stall = '0;
    end else if (stallreq_mem_i) begin
      w_stall = HOLD_MEM;
    end else if (w_ex_req) begin
      w_stall = HOLD_EX;
    end else if (stallreq_id_i) begin
      w_stall = HOLD_ID;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Performance counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((w_stall != 6'b000000) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_o     = w_stall;
  assign flush_o     = !rst && flush_i;
  assign mc_busy_o   = !rst && (r_state == S_RUN);
  assign mc_done_o   = !rst && (r_state == S_DONE);
  assign mc_op_o     = r_op;
  assign mc_cnt_o    = r_cnt;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expectations go through a scoreboard
// queue and are compared against the DUT once its outputs have settled.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id_i = 1'b0;
  logic        stallreq_mem_i = 1'b0;
  logic        mc_start_i = 1'b0;
  logic        mc_op_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        mc_busy_o;
  logic        mc_done_o;
  logic        mc_op_o;
  logic [5:0]  mc_cnt_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_sc = 32'd0;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        flush;
    logic        busy;
    logic        done;
    logic        op;
    logic [5:0]  cnt;
    logic [31:0] sc;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(33), .CNT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_mem_i (stallreq_mem_i),
    .mc_start_i     (mc_start_i),
    .mc_op_i        (mc_op_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .mc_busy_o      (mc_busy_o),
    .mc_done_o      (mc_done_o),
    .mc_op_o        (mc_op_o),
    .mc_cnt_o       (mc_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Input vector packing: {rst, id, mem, start, op, flush}
  function automatic logic [5:0] pk(input logic r, id, mem, st, op, fl);
    return {r, id, mem, st, op, fl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, compare 1 time unit later, posedge follows.
  task automatic cyc(input string tag, input logic [5:0] in, input logic [5:0] e_stall,
                     input logic e_flush, input logic e_busy, input logic e_done,
                     input logic e_op, input logic [5:0] e_cnt);
    exp_t e;
    exp_t g;
    @(negedge clk);
    {rst, stallreq_id_i, stallreq_mem_i, mc_start_i, mc_op_i, flush_i} = in;
    e.tag = tag; e.stall = e_stall; e.flush = e_flush; e.busy = e_busy;
    e.done = e_done; e.op = e_op; e.cnt = e_cnt; e.sc = exp_sc;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk($sformatf("%s.stall", g.tag), {26'd0, stall_o}, {26'd0, g.stall});
    chk($sformatf("%s.flush", g.tag), {31'd0, flush_o}, {31'd0, g.flush});
    chk($sformatf("%s.busy", g.tag), {31'd0, mc_busy_o}, {31'd0, g.busy});
    chk($sformatf("%s.done", g.tag), {31'd0, mc_done_o}, {31'd0, g.done});
    chk($sformatf("%s.op", g.tag), {31'd0, mc_op_o}, {31'd0, g.op});
    chk($sformatf("%s.cnt", g.tag), {26'd0, mc_cnt_o}, {26'd0, g.cnt});
    chk($sformatf("%s.scnt", g.tag), stall_cnt_o, g.sc);
    if (in[5]) exp_sc = 32'd0;
    else if (e_stall != 6'd0 && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
  endtask

  initial begin
    // Reset; combinational outputs stay low even with requests present
    cyc("rst0", pk(1,0,0,0,0,0), 6'b000000, 0, 0, 0, 0, 6'd0);
    cyc("rst1", pk(1,1,1,1,0,1), 6'b000000, 0, 0, 0, 0, 6'd0);

    // Stall priority in IDLE
    cyc("pri_id_mem", pk(0,1,1,0,0,0), 6'b011111, 0, 0, 0, 0, 6'd0);
    cyc("pri_id", pk(0,1,0,0,0,0), 6'b000111, 0, 0, 0, 0, 6'd0);
    cyc("pri_none", pk(0,0,0,0,0,0), 6'b000000, 0, 0, 0, 0, 6'd0);
    cyc("pri_flush", pk(0,1,1,1,0,1), 6'b000000, 1, 0, 0, 0, 6'd0);
    cyc("pri_mem_start", pk(0,0,1,1,0,0), 6'b011111, 0, 0, 0, 0, 6'd0);

    // MUL, no MEM stall: start cycle + 4 RUN cycles, then DONE
    cyc("mul_start", pk(0,0,0,1,0,0), 6'b001111, 0, 0, 0, 0, 6'd0);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("mul_run%0d", i), pk(0,1,0,1,0,0), 6'b001111, 0, 1, 0, 0, 6'(4 - i));
    cyc("mul_done", pk(0,0,0,0,0,0), 6'b000000, 0, 0, 1, 0, 6'd0);
    cyc("mul_idle", pk(0,0,0,0,0,0), 6'b000000, 0, 0, 0, 0, 6'd0);

    // DIV with MEM stall in cycles 5-7: counter frozen, DONE at cycle 37
    cyc("div_start", pk(0,0,0,1,1,0), 6'b001111, 0, 0, 0, 0, 6'd0);
    for (int t = 1; t <= 4; t++)
      cyc($sformatf("div_c%0d", t), pk(0,0,0,1,1,0), 6'b001111, 0, 1, 0, 1, 6'(34 - t));
    for (int t = 5; t <= 7; t++)
      cyc($sformatf("div_mem_c%0d", t), pk(0,0,1,1,1,0), 6'b011111, 0, 1, 0, 1, 6'd29);
    for (int t = 8; t <= 36; t++)
      cyc($sformatf("div_c%0d", t), pk(0,0,0,1,1,0), 6'b001111, 0, 1, 0, 1, 6'(37 - t));
    // DONE held by MEM stall, start ignored while finishing
    cyc("div_done_hold", pk(0,0,1,1,1,0), 6'b011111, 0, 0, 1, 1, 6'd0);
    cyc("div_done", pk(0,0,0,1,1,0), 6'b000000, 0, 0, 1, 1, 6'd0);
    cyc("div_idle", pk(0,0,0,0,0,0), 6'b000000, 0, 0, 0, 1, 6'd0);

    // MUL flushed when the counter reads 2
    cyc("fl_start", pk(0,0,0,1,0,0), 6'b001111, 0, 0, 0, 1, 6'd0);
    cyc("fl_run4", pk(0,0,0,1,0,0), 6'b001111, 0, 1, 0, 0, 6'd4);
    cyc("fl_run3", pk(0,0,0,1,0,0), 6'b001111, 0, 1, 0, 0, 6'd3);
    cyc("fl_flush", pk(0,0,1,1,0,1), 6'b000000, 1, 1, 0, 0, 6'd2);
    cyc("fl_idle0", pk(0,0,0,0,0,0), 6'b000000, 0, 0, 0, 0, 6'd0);
    cyc("fl_idle1", pk(0,0,0,0,0,0), 6'b000000, 0, 0, 0, 0, 6'd0);

    // Reset in the middle of a DIV, then a full-length MUL
    cyc("rr_start", pk(0,0,0,1,1,0), 6'b001111, 0, 0, 0, 0, 6'd0);
    cyc("rr_run33", pk(0,0,0,1,1,0), 6'b001111, 0, 1, 0, 1, 6'd33);
    cyc("rr_run32", pk(0,0,0,1,1,0), 6'b001111, 0, 1, 0, 1, 6'd32);
    cyc("rr_rst", pk(1,0,0,1,1,0), 6'b000000, 0, 0, 0, 1, 6'd31);
    cyc("rr_idle", pk(0,0,0,0,0,0), 6'b000000, 0, 0, 0, 0, 6'd0);
    cyc("rr_mstart", pk(0,0,0,1,0,0), 6'b001111, 0, 0, 0, 0, 6'd0);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("rr_mrun%0d", i), pk(0,0,0,1,0,0), 6'b001111, 0, 1, 0, 0, 6'(4 - i));
    cyc("rr_mdone", pk(0,0,0,0,0,0), 6'b000000, 0, 0, 1, 0, 6'd0);
    cyc("rr_midle", pk(0,0,0,0,0,0), 6'b000000, 0, 0, 0, 0, 6'd0);

    // Stall counter saturation
    @(negedge clk);
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    exp_sc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++)
      cyc($sformatf("sat%0d", i), pk(0,1,0,0,0,0), 6'b000111, 0, 0, 0, 0, 6'd0);
    cyc("sat_end", pk(0,0,0,0,0,0), 6'b000000, 0, 0, 0, 0, 6'd0);
    chk("sat_final", stall_cnt_o, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
